// File: rtl/spi_defines.sv
// spi_defines: shared widths, register map and CTRL bit positions for the SPI block
package spi_defines;
    localparam int SPI_MAX_CHAR      = 128;
    localparam int SPI_CHAR_LEN_BITS = 7;
    localparam int SPI_DIVIDER_LEN   = 16;
    localparam int SPI_SS_NB         = 8;
    localparam logic [4:0] SPI_RX_0   = 5'h00;
    localparam logic [4:0] SPI_RX_1   = 5'h04;
    localparam logic [4:0] SPI_RX_2   = 5'h08;
    localparam logic [4:0] SPI_RX_3   = 5'h0C;
    localparam logic [4:0] SPI_TX_0   = 5'h00;
    localparam logic [4:0] SPI_TX_1   = 5'h04;
    localparam logic [4:0] SPI_TX_2   = 5'h08;
    localparam logic [4:0] SPI_TX_3   = 5'h0C;
    localparam logic [4:0] SPI_CTRL   = 5'h10;
    localparam logic [4:0] SPI_DIVIDE = 5'h14;
    localparam logic [4:0] SPI_SS     = 5'h18;
    localparam int SPI_CTRL_GO     = 8;
    localparam int SPI_CTRL_RX_NEG = 9;
    localparam int SPI_CTRL_TX_NEG = 10;
    localparam int SPI_CTRL_LSB    = 11;
    localparam int SPI_CTRL_IE     = 12;
    localparam int SPI_CTRL_ASS    = 13;
    localparam logic [13:0] SPI_CTRL_MASK = 14'h3F7F;
    localparam logic [SPI_DIVIDER_LEN-1:0] SPI_DIVIDER_DEFAULT = '0;
    function automatic logic adr_valid(input logic [4:0] adr);
        return adr[1:0] == 2'b00 && adr[4:2] <= 3'd6;
    endfunction
    function automatic logic [31:0] lane_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                               input logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) cur[8*i +: 8] = wdat[8*i +: 8];
        return cur;
    endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: divides wb_clk_in into sclk and one-cycle strobes ahead of each sclk edge
module spi_clk_gen #(
    parameter int DIVIDER_LEN = 16
) (
    input  logic                   wb_clk_in,
    input  logic                   wb_rst,
    input  logic                   enable,
    input  logic                   go,
    input  logic                   last,
    input  logic [DIVIDER_LEN-1:0] divider,
    output logic                   sclk,
    output logic                   cpol_0,
    output logic                   cpol_1
);
    logic [DIVIDER_LEN-1:0] cnt;
    logic cnt_zero, cnt_one, div_zero;
    assign cnt_zero = cnt == '0;
    assign cnt_one  = cnt == DIVIDER_LEN'(1);
    assign div_zero = divider == '0;
    // with a zero divider the counter never reaches 1, so strobes follow sclk directly
    always_ff @(posedge wb_clk_in or posedge wb_rst)
        if (wb_rst) begin
            cnt    <= '0;
            sclk   <= 1'b0;
            cpol_0 <= 1'b0;
            cpol_1 <= 1'b0;
        end else begin
            cnt    <= (!enable || cnt_zero) ? divider : cnt - DIVIDER_LEN'(1);
            sclk   <= (enable && cnt_zero && (!last || sclk)) ? ~sclk : sclk;
            cpol_0 <= (enable && cnt_one && !sclk) || (div_zero && ((enable && sclk) || (go && !enable)));
            cpol_1 <= (enable && cnt_one && sclk) || (div_zero && enable && !sclk);
        end
endmodule

// File: rtl/spi_wb_ctrl.sv
// spi_wb_ctrl: Wishbone register slave feeding the SPI shift register, clock divider and slave selects
module spi_wb_ctrl
    import spi_defines::*;
#(
    parameter int DIVIDER_LEN = SPI_DIVIDER_LEN,
    parameter int SS_NB       = SPI_SS_NB
) (
    input  logic                         wb_clk_in,
    input  logic                         wb_rst,
    input  logic [4:0]                   wb_adr_i,
    input  logic [31:0]                  wb_dat_i,
    output logic [31:0]                  wb_dat_o,
    input  logic [3:0]                   wb_sel_i,
    input  logic                         wb_we_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_cyc_i,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic                         wb_int_o,
    output logic [3:0]                   latch,
    output logic [3:0]                   byte_sel,
    output logic [31:0]                  p_in,
    output logic [SPI_CHAR_LEN_BITS-1:0] len,
    output logic                         go,
    output logic                         lsb,
    output logic                         rx_negedge,
    output logic                         tx_negedge,
    input  logic                         tip,
    input  logic                         last,
    input  logic [SPI_MAX_CHAR-1:0]      p_out,
    output logic                         sclk,
    output logic                         cpol_0,
    output logic                         cpol_1,
    output logic [SS_NB-1:0]             ss_pad_o
);
    logic [13:0] ctrl;
    logic [DIVIDER_LEN-1:0] divider;
    logic [SS_NB-1:0] ss;
    logic [127:0] rx_all;
    logic [31:0] rdata;
    logic req, valid, wr, xfer_end;
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign valid    = adr_valid(wb_adr_i);
    assign wr       = req & valid & wb_we_i;
    assign xfer_end = tip & last & cpol_0;
    assign rx_all   = 128'(p_out);
    assign rdata = !valid                   ? '0 :
                   !wb_adr_i[4]             ? rx_all[32*wb_adr_i[3:2] +: 32] :
                   wb_adr_i == SPI_CTRL     ? 32'(ctrl) :
                   wb_adr_i == SPI_DIVIDE   ? 32'(divider) : 32'(ss);
    // TX strobes fire in the request cycle, before ack, so the shift register captures with the access
    assign latch    = (wr && !tip && !wb_adr_i[4]) ? 4'b0001 << wb_adr_i[3:2] : 4'b0000;
    assign byte_sel = |latch ? wb_sel_i : 4'b0000;
    assign p_in     = |latch ? wb_dat_i : 32'h0;
    assign len        = ctrl[SPI_CHAR_LEN_BITS-1:0];
    assign go         = ctrl[SPI_CTRL_GO];
    assign rx_negedge = ctrl[SPI_CTRL_RX_NEG];
    assign tx_negedge = ctrl[SPI_CTRL_TX_NEG];
    assign lsb        = ctrl[SPI_CTRL_LSB];
    assign ss_pad_o   = ~(ss & (ctrl[SPI_CTRL_ASS] ? {SS_NB{tip}} : {SS_NB{1'b1}}));
    always_ff @(posedge wb_clk_in or posedge wb_rst)
        if (wb_rst) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req & valid;
            wb_err_o <= req & ~valid;
            if (req) wb_dat_o <= rdata;
        end
    // end of transfer takes priority; a CTRL write in that cycle still sees go=1 and is dropped
    always_ff @(posedge wb_clk_in or posedge wb_rst)
        if (wb_rst) ctrl <= '0;
        else if (xfer_end) ctrl[SPI_CTRL_GO] <= 1'b0;
        else if (wr && !go && wb_adr_i == SPI_CTRL)
            ctrl <= 14'(lane_merge(32'(ctrl), wb_dat_i, wb_sel_i)) & SPI_CTRL_MASK;
    always_ff @(posedge wb_clk_in or posedge wb_rst)
        if (wb_rst) begin
            divider <= SPI_DIVIDER_DEFAULT;
            ss      <= '0;
        end else if (wr && !go) begin
            if (wb_adr_i == SPI_DIVIDE) divider <= DIVIDER_LEN'(lane_merge(32'(divider), wb_dat_i, wb_sel_i));
            if (wb_adr_i == SPI_SS) ss <= SS_NB'(lane_merge(32'(ss), wb_dat_i, wb_sel_i));
        end
    always_ff @(posedge wb_clk_in or posedge wb_rst)
        if (wb_rst) wb_int_o <= 1'b0;
        else if (xfer_end && ctrl[SPI_CTRL_IE]) wb_int_o <= 1'b1;
        else if (wb_ack_o) wb_int_o <= 1'b0;
    spi_clk_gen #(.DIVIDER_LEN(DIVIDER_LEN)) u_clk_gen (
        .wb_clk_in (wb_clk_in),
        .wb_rst    (wb_rst),
        .enable    (tip),
        .go        (go),
        .last      (last),
        .divider   (divider),
        .sclk      (sclk),
        .cpol_0    (cpol_0),
        .cpol_1    (cpol_1)
    );
endmodule

// File: doc/spi_wb_ctrl.md
# spi_wb_ctrl

Wishbone slave register and control stage directly upstream of the SPI shift register. It decodes host accesses into the shift register's byte-lane latch strobes and static configuration (length, bit order, sampling edges, go). It generates the serial clock and its edge strobes through a divider sub-module. It also drives slave selects, returns received data and raises a transfer-complete interrupt.

## Interface
- SPI_MAX_CHAR, 128, maximum character length in bits (multiple of 32, ≤128)
- SPI_CHAR_LEN_BITS, 7, width of len
- DIVIDER_LEN, 16, divider register width
- SS_NB, 8, number of slave-select lines
- wb_clk_in  in  1  system clock
- wb_rst  in  1  reset, asynchronous, active-high
- wb_adr_i  in  5  byte address
- wb_dat_i / wb_dat_o  in/out  32  write/read data
- wb_sel_i  in  4  byte lane selects
- wb_we_i, wb_stb_i, wb_cyc_i  in  1  Wishbone controls
- wb_ack_o, wb_err_o, wb_int_o  out  1  acknowledge, error, interrupt
- latch  out  4  TX word strobe, one-hot, to shift register
- byte_sel  out  4  lanes for latch
- p_in  out  32  write data to shift register
- len  out  SPI_CHAR_LEN_BITS  character length (0 = SPI_MAX_CHAR)
- go, lsb, rx_negedge, tx_negedge  out  1  control fields
- tip, last  in  1  from shift register
- p_out  in  SPI_MAX_CHAR  received data
- sclk, cpol_0, cpol_1  out  1  serial clock, rising-edge strobe, falling-edge strobe
- ss_pad_o  out  SS_NB  active-low slave selects

## Operation
- Map (word-aligned): 0x00–0x0C RX0–RX3 (read p_out[32i+31:32i]) / TX0–TX3 (write); 0x10 CTRL; 0x14 DIVIDER; 0x18 SS.
- Any other offset, or adr[1:0]≠0: wb_err_o instead of ack; no side effects; reads return 0.
- CTRL bits: [6:0] len, [8] GO_BSY, [9] rx_negedge, [10] tx_negedge, [11] lsb, [12] IE, [13] ASS.
- Reads of CTRL return the current GO_BSY state.
- CTRL/DIVIDER/SS writes are byte-lane gated by wb_sel_i. They are ignored while go=1; the access still acks.
- A TX write is accepted only when tip=0; the access still acks.
- Each accepted TX write drives latch[i]=1, byte_sel=wb_sel_i and p_in=wb_dat_i for exactly one cycle (the request cycle, ack not yet high).
- go is set by a CTRL write with bit 8=1 (lane 1). It clears in the cycle after tip&last&cpol_0.
- Interrupt flag is set at the end of a transfer (same condition) when IE=1. It is cleared by any acknowledged access. wb_int_o is the registered flag.
- ss_pad_o = ~(SS & (ASS ? {SS_NB{tip}} : all-ones)).
- Clock gen (enabled by tip):
  - Counter reloads DIVIDER when 0 or disabled.
  - sclk toggles at counter 0, except that a rising toggle is suppressed when last=1.
  - Period = 2·(DIVIDER+1) wb_clk_in cycles.
  - cpol_0/cpol_1 pulse one cycle when the counter is 1 and the next toggle is rising/falling.
  - DIVIDER=0: strobes alternate every cycle, plus a cpol_0 pulse on go&!tip to launch the first bit.

## Timing
- Reset values:
  - wb_ack_o, wb_err_o, wb_int_o, wb_dat_o: 0.
  - All CTRL fields 0. DIVIDER 0. SS 0, so ss_pad_o all ones.
  - sclk 0. cpol_0, cpol_1, latch 0.
- Handshake: wb_ack_o <= cyc&stb&~ack&valid. Single-cycle ack, one idle cycle between back-to-back accesses. wb_dat_o registered with ack.
- Simultaneous go-clear and CTRL write: the write is ignored (go=1) and go clears.
- Simultaneous interrupt set and access ack: set wins.
- Reset mid-transfer: all state returns to reset values within the same clock.

## Structure
- Shared spi_defines package holds:
  - SPI_MAX_CHAR and SPI_CHAR_LEN_BITS.
  - Register offsets SPI_RX_0..3, SPI_TX_0..3, SPI_CTRL, SPI_DIVIDE, SPI_SS.
  - CTRL bit indices.
  - Default divider.
- Sub-module spi_clk_gen (divider, sclk, cpol_0, cpol_1); everything else flat.

## Test plan
- Reset release -> ss_pad_o=0xFF, sclk=0, all Wishbone outputs 0; read CTRL returns 0.
- Write TX1=0xA5A5A5A5, sel=0x3, tip=0 -> latch=0010, byte_sel=0011, p_in=0xA5A5A5A5 for one cycle; ack next cycle.
- DIVIDER=1, CTRL=0x1108 (len 8, GO, IE), SS=1 -> go=1, ss_pad_o=0xFE:
  - sclk period 4 cycles, 8 rising edges.
  - go clears after last.
  - wb_int_o=1 until the next access.
- During go=1, write DIVIDER=5 -> acked, DIVIDER still 1.
- Access 0x1C and 0x05 -> wb_err_o pulse, no ack, no register change.
- Assert wb_rst mid-transfer -> sclk=0, go=0, ss_pad_o=0xFF immediately.
